// File: rtl/sha256_msg_sched.sv
// rtl/sha256_msg_sched.sv - SHA-256 message schedule: loads 16 words, streams W[0..63]
// A 16-word sliding window produces each W[t+16] in the same cycle W[t] is consumed.
module sha256_msg_sched (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        w_valid,
   input  logic        w_ready,
   output logic [31:0] w_data,
   output logic [5:0]  w_idx,
   output logic        w_last
);

   typedef enum logic {
      LOAD = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [5:0]  cnt;
   logic [5:0]  cnt_nxt;
   logic [31:0] win [16];
   logic        in_hs;
   logic        w_hs;
   logic        shift;
   logic        block_end;
   logic [31:0] new_word;
   logic [31:0] shift_word;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   // All outputs decode from registers only; nothing combinational from in_* or w_ready.
   assign in_ready = (state == LOAD);
   assign w_valid  = (state == EMIT);
   assign w_data   = win[0];
   assign w_idx    = cnt;
   assign w_last   = (state == EMIT) && (cnt == 6'd63);

   assign in_hs = in_valid && (state == LOAD);
   assign w_hs  = w_ready && (state == EMIT);
   assign shift = in_hs || w_hs;

   // Words computed past t = 47 are never emitted, so no guard is needed on new_word.
   assign new_word   = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
   assign shift_word = in_hs ? in_data : new_word;

   assign block_end = (in_hs && (cnt == 6'd15)) || (w_hs && (cnt == 6'd63));

   always_comb begin
      cnt_nxt = cnt;
      if (shift) begin
         cnt_nxt = block_end ? 6'd0 : cnt + 6'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD: if (in_hs && (cnt == 6'd15)) state_nxt = EMIT;
         EMIT: if (w_hs && (cnt == 6'd63)) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 6'd0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            win[i] <= 32'h0;
         end
      end else if (shift) begin
         for (int i = 0; i < 15; i++) begin
            win[i] <= win[i+1];
         end
         win[15] <= shift_word;
      end
   end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb/tb_sha256_msg_sched.sv - self-checking bench for sha256_msg_sched
// Directed blocks checked against a recurrence model and a table of hand-computed words.
module tb_sha256_msg_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        w_valid;
   logic        w_ready;
   logic [31:0] w_data;
   logic [5:0]  w_idx;
   logic        w_last;

   sha256_msg_sched dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .w_valid  (w_valid),
      .w_ready  (w_ready),
      .w_data   (w_data),
      .w_idx    (w_idx),
      .w_last   (w_last)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] msg [16];
   logic [31:0] res [8][64];

   typedef struct {
      string       name;
      int          slot;
      int          idx;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   task automatic set_abc();
      for (int i = 0; i < 16; i++) msg[i] = 32'h0;
      msg[0]  = 32'h61626380;
      msg[15] = 32'h00000018;
   endtask

   // Entered and left at a falling edge so back-to-back calls leave no idle cycle.
   task automatic run_block(input int bubble, input bit stall, input bit hold_valid,
                            input int abort_idx, input int slot);
      logic [31:0] gold [64];
      int          acc;
      int          n;
      int          budget;
      int          stall_left;
      int          last_idx;
      int          emit_ready;
      int          stab_err;
      int          idle_valid;
      bit          hs;
      bit          prev_stalled;
      logic [31:0] pd;
      logic [5:0]  pi;
      logic        pl;

      for (int t = 0; t < 16; t++) gold[t] = msg[t];
      for (int t = 16; t < 64; t++)
         gold[t] = ssig1(gold[t-2]) + gold[t-7] + ssig0(gold[t-15]) + gold[t-16];

      acc = 0;
      budget = 0;
      while (acc < 16 && budget < 400) begin
         if (bubble > 0 && int'($urandom_range(0, 99)) < bubble) begin
            in_valid = 1'b0;
            in_data  = $urandom;
         end else begin
            in_valid = 1'b1;
            in_data  = msg[acc];
         end
         w_ready = 1'($urandom_range(0, 1));
         hs = in_valid && in_ready;
         @(negedge clk);
         budget++;
         if (hs) acc++;
      end
      check("load_count", 32'(acc), 32'd16);
      check("emit_start", {24'h0, w_valid, in_ready, w_idx}, {24'h0, 1'b1, 1'b0, 6'd0});

      n = 0;
      budget = 0;
      stall_left = 0;
      last_idx = -1;
      emit_ready = 0;
      stab_err = 0;
      prev_stalled = 1'b0;
      pd = 32'h0;
      pi = 6'd0;
      pl = 1'b0;
      while (n < 64 && budget < 2000) begin
         if (prev_stalled && ({w_data, w_idx, w_last} !== {pd, pi, pl})) stab_err++;
         if (in_ready) emit_ready++;
         if (abort_idx >= 0 && w_valid && int'(w_idx) == abort_idx) begin
            rst_n = 1'b0;
            #1;
            check("abort_w_valid", 32'(w_valid), 32'd0);
            check("abort_in_ready", 32'(in_ready), 32'd1);
            check("abort_w_idx", 32'(w_idx), 32'd0);
            in_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            idle_valid = 0;
            repeat (4) begin
               @(negedge clk);
               if (w_valid || !in_ready) idle_valid++;
            end
            check("abort_no_output", 32'(idle_valid), 32'd0);
            return;
         end
         if (int'(w_idx) != last_idx) begin
            last_idx = int'(w_idx);
            stall_left = (stall && (w_idx == 6'd20 || w_idx == 6'd63)) ? 5 : 0;
         end
         if (stall_left > 0) begin
            w_ready = 1'b0;
            stall_left--;
         end else begin
            w_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         in_valid = hold_valid;
         in_data  = $urandom;
         hs = w_valid && w_ready;
         prev_stalled = w_valid && !w_ready;
         pd = w_data;
         pi = w_idx;
         pl = w_last;
         if (hs) begin
            res[slot][n] = w_data;
            check($sformatf("w_data[%0d]", n), w_data, gold[n]);
            check($sformatf("w_idx[%0d]", n), 32'(w_idx), 32'(n));
            check($sformatf("w_last[%0d]", n), 32'(w_last), 32'(n == 63));
         end
         @(negedge clk);
         budget++;
         if (hs) n++;
      end
      check("emit_count", 32'(n), 32'd64);
      check("in_ready_in_emit", 32'(emit_ready), 32'd0);
      check("stall_stable", 32'(stab_err), 32'd0);
      check("turnaround", {30'h0, in_ready, w_valid}, {30'h0, 1'b1, 1'b0});
      in_valid = 1'b0;
   endtask

   initial begin
      vecs[0] = '{"abc_w0",   0, 0,  32'h61626380};
      vecs[1] = '{"abc_w1",   0, 1,  32'h00000000};
      vecs[2] = '{"abc_w15",  0, 15, 32'h00000018};
      vecs[3] = '{"abc_w16",  0, 16, 32'h61626380};
      vecs[4] = '{"abc_w17",  0, 17, 32'h000F0000};
      vecs[5] = '{"abc_w18",  0, 18, 32'h7DA86405};
      vecs[6] = '{"ones_w0",  1, 0,  32'hFFFFFFFF};
      vecs[7] = '{"ones_w16", 1, 16, 32'h203FFFFC};
      vecs[8] = '{"stall_w17", 2, 17, 32'h000F0000};

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 32'h0;
      w_ready  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_w_valid", 32'(w_valid), 32'd0);
      check("rst_w_data", w_data, 32'd0);
      check("rst_w_idx", 32'(w_idx), 32'd0);
      check("rst_w_last", 32'(w_last), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_outputs", {24'h0, in_ready, w_valid, w_idx}, {24'h0, 1'b1, 1'b0, 6'd0});

      set_abc();
      run_block(0, 1'b0, 1'b0, -1, 0);

      for (int i = 0; i < 16; i++) msg[i] = 32'hFFFFFFFF;
      run_block(0, 1'b0, 1'b0, -1, 1);

      set_abc();
      run_block(30, 1'b1, 1'b1, -1, 2);
      for (int i = 0; i < 64; i++)
         check($sformatf("stall_vs_nostall[%0d]", i), res[2][i], res[0][i]);

      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_data  = 32'hDEADBEEF + 32'(i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("load_abort_outputs", {24'h0, in_ready, w_valid, w_idx}, {24'h0, 1'b1, 1'b0, 6'd0});
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      set_abc();
      run_block(0, 1'b0, 1'b0, -1, 3);

      run_block(0, 1'b0, 1'b1, 30, 4);
      set_abc();
      run_block(0, 1'b0, 1'b0, -1, 7);

      for (int i = 0; i < 16; i++) msg[i] = 32'h9E3779B9 * 32'(i + 1);
      run_block(0, 1'b0, 1'b1, -1, 5);
      for (int i = 0; i < 16; i++) msg[i] = (32'h01010101 * 32'(i)) ^ 32'h5A5A0000;
      run_block(0, 1'b0, 1'b1, -1, 6);

      for (int i = 0; i < 9; i++)
         check(vecs[i].name, res[vecs[i].slot][vecs[i].idx], vecs[i].exp);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
